rx_packetizer: RTL and testbench
================================

RX_PACKETIZER -- requirements
Module: rx_packetizer

Interface
REQ-001 Parameter WORDS, default 82, 48-bit words per receive page.
REQ-002 Parameter SYNC0, default 8'h5A, first header byte.
REQ-003 Parameter SYNC1, default 8'hA5, second header byte.
REQ-004 clock  input  1  single clock; all logic rising-edge; same domain as receiver page writer.
REQ-005 reset  input  1  asynchronous, active-high.
REQ-006 rx_on  input  1  receiver enable; low aborts and holds block idle.
REQ-007 mem_block  input  1  index of the page readable by this block; toggles when the writer completes a page.
REQ-008 rd_addr  output  8  page RAM read address {page, word[6:0]}.
REQ-009 rd_data  input  48  page RAM read data, valid exactly 1 cycle after rd_addr.
REQ-010 out_data  output  8  byte stream.
REQ-011 out_valid  output  1  out_data valid.
REQ-012 out_ready  input  1  sink accepts byte when out_valid&&out_ready (transfer).
REQ-013 out_last  output  1  high with final byte of a packet.
REQ-014 busy  output  1  high whenever state is not IDLE.
REQ-015 overrun_cnt  output  8  saturating count of dropped pages.

Function
REQ-016 Packet = 4 header bytes {SYNC0, SYNC1, seq[7:0], {7'b0, ovf}} followed by WORDS*6 data bytes (492 at default), 496 bytes total.
REQ-017 Data bytes per word sent MSB first: [47:40] ... [7:0]; words sent in address order 0..WORDS-1.
REQ-018 Page event = rx_on && primed && (mem_block != mem_block_d); mem_block_d registers mem_block every cycle; primed sets one cycle after reset release or rx_on rising, so no event fires on the first sampled value.
REQ-019 States: IDLE, HDR, FETCH, WAIT, SEND.
REQ-020 IDLE: on page event latch page=mem_block, word=0, hbyte=0 -> HDR.
REQ-021 HDR: out_valid=1, out_data=header[hbyte]; on transfer hbyte++; transfer of hbyte==3 -> FETCH.
REQ-022 FETCH: drive rd_addr={page, word[6:0]}, out_valid=0 -> WAIT.
REQ-023 WAIT: capture rd_data into 48-bit shift register, bcnt=0 -> SEND.
REQ-024 SEND: out_valid=1, out_data=shift[47:40]; on transfer shift left 8, bcnt++; transfer of bcnt==5: if word==WORDS-1 -> IDLE, else word++ -> FETCH.
REQ-025 out_last=1 only in SEND with word==WORDS-1 and bcnt==5.
REQ-026 out_data, out_last held stable while out_valid && !out_ready; out_valid never drops without a transfer except on abort (REQ-030).
REQ-027 seq increments by 1 (mod 256) on transfer of out_last; first packet after reset or rx_on rising carries seq=0.
REQ-028 Page event while not IDLE: page dropped, current packet unaffected, overrun_cnt += 1 saturating at 255, ovf sticky set.
REQ-029 ovf is cleared when header byte 3 of the next packet transfers; an event coinciding with that transfer keeps ovf set.
REQ-030 rx_on low: next cycle state=IDLE, out_valid=0, out_last=0, seq=0, ovf=0, primed=0; overrun_cnt held.
REQ-031 Packet throughput with out_ready held high: 4 + WORDS*8 cycles (660 at default); minimum page period supported without overrun equals this plus one IDLE cycle.

Reset
REQ-032 During reset: state=IDLE, rd_addr=0, out_data=0, out_valid=0, out_last=0, busy=0, overrun_cnt=0, seq=0, ovf=0, primed=0, mem_block_d=0, shift=0.
REQ-033 Reset asserted mid-packet aborts immediately; no partial packet resumes after release.

Verification
REQ-034 rx_on=1, out_ready=1, page 0 preloaded word k=48'h000000000000+k, toggle mem_block 0->1 -> exactly 496 bytes: 5A A5 00 00 then 00 00 00 00 00 00, 00 00 00 00 00 01, ..., last byte 8'h51 with out_last=1, total 660 cycles busy.
REQ-035 Same stimulus, out_ready toggled pseudo-randomly -> identical byte sequence, out_data stable while stalled, no byte lost or duplicated.
REQ-036 Second mem_block toggle 100 cycles into a packet -> packet completes intact, overrun_cnt=1, next packet header byte 3 = 8'h01, following packet byte 3 = 8'h00.
REQ-037 Three back-to-back pages spaced 700 cycles, out_ready=1 -> seq fields 00, 01, 02; overrun_cnt stays 0; rd_addr page bit alternates 1,0,1 per mem_block.
REQ-038 rx_on dropped at byte 200 -> out_valid=0 next cycle, busy=0; rx_on raised, mem_block at constant 1 -> no packet until next toggle, then seq=0.
REQ-039 reset pulsed mid-SEND and with mem_block=1 at release -> all outputs at REQ-032 values, no spurious packet after release.

Source files
------------

// File: rtl/rx_packetizer_if.sv
// Bundle of page-RAM read port, receiver control and output byte stream
// signals around rx_packetizer. The packetizer sits on the master side;
// the environment (page writer, RAM, byte sink) sits on the slave side.
interface rx_packetizer_if;
   logic        rx_on;
   logic        mem_block;
   logic [7:0]  rd_addr;
   logic [47:0] rd_data;
   logic [7:0]  out_data;
   logic        out_valid;
   logic        out_ready;
   logic        out_last;
   logic        busy;
   logic [7:0]  overrun_cnt;

   modport master (
      input  rx_on,
      input  mem_block,
      input  rd_data,
      input  out_ready,
      output rd_addr,
      output out_data,
      output out_valid,
      output out_last,
      output busy,
      output overrun_cnt
   );

   modport slave (
      output rx_on,
      output mem_block,
      output rd_data,
      output out_ready,
      input  rd_addr,
      input  out_data,
      input  out_valid,
      input  out_last,
      input  busy,
      input  overrun_cnt
   );
endinterface

// File: rtl/rx_packetizer.sv
// Turns each completed receive page (WORDS x 48-bit words) into a byte
// packet: a 4-byte header {SYNC0, SYNC1, seq, ovf} followed by the page
// words, most significant byte first. Pages that complete while a packet
// is still going out are dropped and counted.
module rx_packetizer #(
   parameter int         WORDS = 82,
   parameter logic [7:0] SYNC0 = 8'h5A,
   parameter logic [7:0] SYNC1 = 8'hA5
) (
   input logic             clock,
   input logic             reset,
   rx_packetizer_if.master bus
);

   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_HDR   = 3'd1;
   localparam logic [2:0] ST_FETCH = 3'd2;
   localparam logic [2:0] ST_WAIT  = 3'd3;
   localparam logic [2:0] ST_SEND  = 3'd4;

   localparam logic [6:0] LAST_WORD = 7'(WORDS - 1);

   logic [2:0]  state_q,     state_d;
   logic        page_q,      page_d;
   logic [6:0]  word_q,      word_d;
   logic [1:0]  hByte_q,     hByte_d;
   logic [2:0]  bCnt_q,      bCnt_d;
   logic [47:0] shift_q,     shift_d;
   logic [7:0]  seq_q,       seq_d;
   logic        ovf_q,       ovf_d;
   logic [7:0]  overrun_q,   overrun_d;
   logic        primed_q;
   logic        memBlockDly_q;

   logic        pageEvent;
   logic        outValid;
   logic        transfer;
   logic [7:0]  headerByte;

   // A page event is a change of the writer's page index, ignored until the
   // block has seen one settled sample since reset release or rx_on rising.
   assign pageEvent = bus.rx_on && primed_q && (bus.mem_block != memBlockDly_q);
   assign outValid  = (state_q == ST_HDR) || (state_q == ST_SEND);
   assign transfer  = outValid && bus.out_ready;

   // Header byte currently on offer, indexed by the header byte counter.
   always_comb begin
      headerByte = SYNC0;
      case (hByte_q)
         2'd0:    headerByte = SYNC0;
         2'd1:    headerByte = SYNC1;
         2'd2:    headerByte = seq_q;
         default: headerByte = {7'b0, ovf_q};
      endcase
   end

   assign bus.out_valid   = outValid;
   assign bus.out_data    = (state_q == ST_HDR)  ? headerByte :
                            (state_q == ST_SEND) ? shift_q[47:40] : 8'h00;
   assign bus.out_last    = (state_q == ST_SEND) && (word_q == LAST_WORD) && (bCnt_q == 3'd5);
   assign bus.busy        = (state_q != ST_IDLE);
   assign bus.rd_addr     = {page_q, word_q};
   assign bus.overrun_cnt = overrun_q;

   // Packet sequencing: header, then per word a read cycle, a capture cycle
   // and six byte transfers; overrun bookkeeping and rx_on abort override
   // the normal flow at the end.
   always_comb begin
      state_d   = state_q;
      page_d    = page_q;
      word_d    = word_q;
      hByte_d   = hByte_q;
      bCnt_d    = bCnt_q;
      shift_d   = shift_q;
      seq_d     = seq_q;
      ovf_d     = ovf_q;
      overrun_d = overrun_q;

      case (state_q)
         ST_IDLE: begin
            if (pageEvent) begin
               page_d  = bus.mem_block;
               word_d  = 7'd0;
               hByte_d = 2'd0;
               state_d = ST_HDR;
            end
         end
         ST_HDR: begin
            if (transfer) begin
               hByte_d = hByte_q + 2'd1;
               if (hByte_q == 2'd3) begin
                  ovf_d   = 1'b0;
                  state_d = ST_FETCH;
               end
            end
         end
         ST_FETCH: begin
            state_d = ST_WAIT;
         end
         ST_WAIT: begin
            shift_d = bus.rd_data;
            bCnt_d  = 3'd0;
            state_d = ST_SEND;
         end
         ST_SEND: begin
            if (transfer) begin
               shift_d = {shift_q[39:0], 8'h00};
               bCnt_d  = bCnt_q + 3'd1;
               if (bCnt_q == 3'd5) begin
                  if (word_q == LAST_WORD) begin
                     seq_d   = seq_q + 8'd1;
                     state_d = ST_IDLE;
                  end else begin
                     word_d  = word_q + 7'd1;
                     state_d = ST_FETCH;
                  end
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      if (pageEvent && (state_q != ST_IDLE)) begin
         ovf_d = 1'b1;
         if (overrun_q != 8'hFF) begin
            overrun_d = overrun_q + 8'd1;
         end
      end

      if (!bus.rx_on) begin
         state_d = ST_IDLE;
         seq_d   = 8'd0;
         ovf_d   = 1'b0;
      end
   end

   // State registers; primed follows rx_on so the first sample after reset
   // release or enable never counts as a page event.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q       <= ST_IDLE;
         page_q        <= 1'b0;
         word_q        <= 7'd0;
         hByte_q       <= 2'd0;
         bCnt_q        <= 3'd0;
         shift_q       <= 48'd0;
         seq_q         <= 8'd0;
         ovf_q         <= 1'b0;
         overrun_q     <= 8'd0;
         primed_q      <= 1'b0;
         memBlockDly_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         page_q        <= page_d;
         word_q        <= word_d;
         hByte_q       <= hByte_d;
         bCnt_q        <= bCnt_d;
         shift_q       <= shift_d;
         seq_q         <= seq_d;
         ovf_q         <= ovf_d;
         overrun_q     <= overrun_d;
         primed_q      <= bus.rx_on;
         memBlockDly_q <= bus.mem_block;
      end
   end

endmodule

// File: tb/tb_rx_packetizer.sv
// Self-checking bench for rx_packetizer: a packet-level reference model
// (expected byte queue built from page contents, sequence/overflow rules,
// overrun counting) is compared against the DUT every cycle, while
// directed and randomized page toggles, back-pressure and aborts drive it.
module tb_rx_packetizer;

   localparam int WORDS = 82;

   logic clock = 1'b0;
   logic reset;

   rx_packetizer_if bus();

   logic [47:0] mem [0:255];
   logic [47:0] rdData;

   rx_packetizer #(.WORDS(WORDS), .SYNC0(8'h5A), .SYNC1(8'hA5)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   // 100 MHz clock.
   always #5 clock = ~clock;

   // Page RAM with one cycle of read latency.
   always @(posedge clock) rdData <= mem[bus.rd_addr];
   assign bus.rd_data = rdData;

   int passCount  = 0;
   int totalCount = 0;

   // Reference model state.
   int expQ[$];
   bit mBusy, mOvf, mPrimed, mMbPrev, mPage;
   int mSeq, mOvr;

   // Log of packets as actually emitted by the DUT.
   int pktCount, pktIdx, busyCycles;
   int logLen[128], logSeq[128], logOvf[128], logLast[128], logPage[128];
   int first10[10];

   bit prevStall;
   int prevData, prevLast;
   bit randReady;
   bit mbState;

   task automatic checkOutput(input string name, input int actual, input int expected);
      totalCount++;
      if (actual == expected) passCount++;
      else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
   endtask

   // Expected byte list for one page; 256 marks the ovf header byte, whose
   // value is only known when it is offered; bit 9 flags the final byte.
   task automatic startPacket(input bit page);
      logic [47:0] w;
      expQ.push_back(8'h5A);
      expQ.push_back(8'hA5);
      expQ.push_back(mSeq);
      expQ.push_back(256);
      for (int i = 0; i < WORDS; i++) begin
         w = mem[{page, 7'(i)}];
         for (int b = 5; b >= 0; b--) begin
            expQ.push_back(int'(w[8*b +: 8]) | (((i == WORDS - 1) && (b == 0)) ? 512 : 0));
         end
      end
   endtask

   // Compare process: checks outputs at the negedge, then advances the model
   // by what the coming rising edge will do with the current inputs.
   always @(negedge clock) begin
      bit xfer, ev, busyBefore, endPkt;
      int head, expByte;
      if (reset) begin
         checkOutput("rst_valid", int'(bus.out_valid), 0);
         checkOutput("rst_data", int'(bus.out_data), 0);
         checkOutput("rst_last", int'(bus.out_last), 0);
         checkOutput("rst_busy", int'(bus.busy), 0);
         checkOutput("rst_addr", int'(bus.rd_addr), 0);
         checkOutput("rst_overrun", int'(bus.overrun_cnt), 0);
         expQ.delete();
         mBusy = 0; mOvf = 0; mSeq = 0; mOvr = 0; mPrimed = 0; mMbPrev = 0;
         pktIdx = 0; prevStall = 0;
      end else begin
         if (prevStall) begin
            checkOutput("stall_valid", int'(bus.out_valid), 1);
            checkOutput("stall_data", int'(bus.out_data), prevData);
            checkOutput("stall_last", int'(bus.out_last), prevLast);
         end
         checkOutput("busy", int'(bus.busy), int'(mBusy));
         checkOutput("overrun_cnt", int'(bus.overrun_cnt), mOvr);
         if (mBusy) checkOutput("rd_page", int'(bus.rd_addr[7]), int'(mPage));
         if (bus.out_valid) begin
            if (expQ.size() == 0) checkOutput("spurious_valid", 1, 0);
            else begin
               expByte = (expQ[0] == 256) ? int'(mOvf) : (expQ[0] & 255);
               checkOutput("out_data", int'(bus.out_data), expByte);
               checkOutput("out_last", int'(bus.out_last), (expQ[0] >> 9) & 1);
            end
         end
         if (bus.busy) busyCycles++;

         xfer = bus.out_valid && bus.out_ready;
         if (!bus.rx_on) begin
            expQ.delete();
            mBusy = 0; mSeq = 0; mOvf = 0; pktIdx = 0;
         end else begin
            busyBefore = mBusy;
            ev = mPrimed && (bus.mem_block != mMbPrev);
            endPkt = 0;
            if (xfer) begin
               if (pktCount < 128) begin
                  if (pktIdx == 0) logPage[pktCount] = int'(bus.rd_addr[7]);
                  if (pktIdx == 2) logSeq[pktCount] = int'(bus.out_data);
                  if (pktIdx == 3) logOvf[pktCount] = int'(bus.out_data);
                  if (pktCount == 0 && pktIdx < 10) first10[pktIdx] = int'(bus.out_data);
                  pktIdx++;
                  if (bus.out_last) begin
                     logLen[pktCount]  = pktIdx;
                     logLast[pktCount] = int'(bus.out_data);
                     pktCount++;
                     pktIdx = 0;
                  end
               end
               if (expQ.size() > 0) begin
                  head = expQ.pop_front();
                  if (head == 256) mOvf = 0;
                  if (head[9]) begin
                     mSeq = (mSeq + 1) % 256;
                     endPkt = 1;
                  end
               end
            end
            if (ev) begin
               if (busyBefore) begin
                  if (mOvr < 255) mOvr++;
                  mOvf = 1;
               end else begin
                  mPage = bus.mem_block;
                  startPacket(mPage);
                  mBusy = 1;
               end
            end
            if (endPkt) mBusy = 0;
         end
         prevStall = bus.out_valid && !bus.out_ready && bus.rx_on;
         prevData  = int'(bus.out_data);
         prevLast  = int'(bus.out_last);
         mPrimed   = bus.rx_on;
         mMbPrev   = bus.mem_block;
      end
   end

   // Pseudo-random back-pressure when enabled.
   initial begin
      forever begin
         @(posedge clock);
         #3;
         if (randReady) bus.out_ready = 1'($urandom_range(0, 1));
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clock);
      #2;
   endtask

   task automatic applyStimulus(input bit mb);
      mbState = mb;
      bus.mem_block = mb;
   endtask

   task automatic waitIdle(input string name, input int budget);
      int c = 0;
      while ((mBusy || bus.busy) && c < budget) begin
         tick(1);
         c++;
      end
      if (c >= budget) checkOutput(name, 0, 1);
   endtask

   // Safety net against a hung run.
   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int expFirst[10] = '{8'h5A, 8'hA5, 0, 0, 0, 0, 0, 0, 0, 0};
      int base, c;

      randReady = 0;
      pktCount = 0; pktIdx = 0; busyCycles = 0;
      reset = 1'b1;
      bus.rx_on = 1'b1;
      bus.out_ready = 1'b1;
      applyStimulus(1'b0);
      for (int a = 0; a < 256; a++) mem[a] = 48'(a % 128);
      tick(3);
      reset = 1'b0;
      tick(3);

      $display("[TB] single packet, sink always ready");
      busyCycles = 0;
      applyStimulus(1'b1);
      tick(2);
      waitIdle("pkt0_timeout", 1000);
      checkOutput("pkt0_len", logLen[0], 496);
      for (int i = 0; i < 10; i++) checkOutput("pkt0_head_bytes", first10[i], expFirst[i]);
      checkOutput("pkt0_last_byte", logLast[0], 8'h51);
      checkOutput("pkt0_busy_cycles", busyCycles, 660);
      checkOutput("pkt0_seq", logSeq[0], 0);
      checkOutput("pkt0_ovf", logOvf[0], 0);

      $display("[TB] packet under random back-pressure");
      randReady = 1;
      applyStimulus(1'b0);
      tick(2);
      waitIdle("pkt1_timeout", 5000);
      randReady = 0;
      bus.out_ready = 1'b1;
      checkOutput("pkt1_len", logLen[1], 496);
      checkOutput("pkt1_last_byte", logLast[1], 8'h51);
      checkOutput("pkt1_seq", logSeq[1], 1);

      $display("[TB] overrun mid-packet");
      tick(5);
      applyStimulus(1'b1);
      tick(100);
      applyStimulus(1'b0);
      tick(2);
      waitIdle("pkt2_timeout", 1000);
      checkOutput("pkt2_len", logLen[2], 496);
      checkOutput("overrun_after_drop", int'(bus.overrun_cnt), 1);
      applyStimulus(1'b1);
      tick(2);
      waitIdle("pkt3_timeout", 1000);
      checkOutput("pkt3_ovf", logOvf[3], 1);
      applyStimulus(1'b0);
      tick(2);
      waitIdle("pkt4_timeout", 1000);
      checkOutput("pkt4_ovf", logOvf[4], 0);

      $display("[TB] back-to-back pages 700 cycles apart");
      applyStimulus(1'b1);
      tick(700);
      applyStimulus(1'b0);
      tick(700);
      applyStimulus(1'b1);
      tick(2);
      waitIdle("b2b_timeout", 1000);
      checkOutput("b2b_seq0", logSeq[5], 5);
      checkOutput("b2b_seq1", logSeq[6], 6);
      checkOutput("b2b_seq2", logSeq[7], 7);
      checkOutput("b2b_page0", logPage[5], 1);
      checkOutput("b2b_page1", logPage[6], 0);
      checkOutput("b2b_page2", logPage[7], 1);
      checkOutput("b2b_overrun", int'(bus.overrun_cnt), 1);

      $display("[TB] randomized pages, back-pressure and aborts");
      for (int a = 0; a < 256; a++) mem[a] = {16'($urandom), 32'($urandom)};
      for (int i = 0; i < 25; i++) begin
         randReady = 1'($urandom_range(0, 1));
         if (!randReady) bus.out_ready = 1'b1;
         if ($urandom_range(0, 5) == 0) begin
            tick($urandom_range(20, 400));
            bus.rx_on = 1'b0;
            tick($urandom_range(1, 4));
            bus.rx_on = 1'b1;
         end
         applyStimulus(~mbState);
         tick($urandom_range(50, 900));
      end
      waitIdle("random_timeout", 8000);
      randReady = 0;
      bus.out_ready = 1'b1;

      $display("[TB] rx_on abort mid-packet");
      tick(3);
      applyStimulus(~mbState);
      c = 0;
      while (pktIdx < 200 && c < 2000) begin
         tick(1);
         c++;
      end
      if (c >= 2000) checkOutput("abort_wait_timeout", 0, 1);
      bus.rx_on = 1'b0;
      tick(1);
      checkOutput("abort_valid", int'(bus.out_valid), 0);
      checkOutput("abort_busy", int'(bus.busy), 0);
      bus.rx_on = 1'b1;
      base = pktCount;
      tick(50);
      checkOutput("abort_no_packet", pktCount, base);
      checkOutput("abort_idle", int'(bus.busy), 0);
      applyStimulus(~mbState);
      tick(2);
      waitIdle("abort_pkt_timeout", 1000);
      checkOutput("abort_seq_restart", logSeq[pktCount - 1], 0);

      $display("[TB] reset pulse mid-packet");
      if (mbState) begin
         applyStimulus(1'b0);
         tick(2);
         waitIdle("pre_rst_timeout", 1000);
      end
      applyStimulus(1'b1);
      tick(100);
      reset = 1'b1;
      tick(1);
      checkOutput("rst_mid_valid", int'(bus.out_valid), 0);
      checkOutput("rst_mid_overrun", int'(bus.overrun_cnt), 0);
      tick(2);
      reset = 1'b0;
      base = pktCount;
      tick(30);
      checkOutput("rst_no_packet", pktCount, base);
      checkOutput("rst_idle", int'(bus.busy), 0);
      applyStimulus(1'b0);
      tick(2);
      waitIdle("post_rst_timeout", 1000);
      checkOutput("post_rst_seq", logSeq[pktCount - 1], 0);
      checkOutput("post_rst_len", logLen[pktCount - 1], 496);

      tick(5);
      $display("%0d/%0d checks passed", passCount, totalCount);
      $finish;
   end

endmodule
